branch_predict_unit: RTL and testbench

- IF-stage branch predictor that produces the per-instruction prediction record (PResult) travelling down the pipeline to the EXE branch-resolve logic.
- Consumes the EXE correction record (BResult) to train its BTB, 2-bit direction counters and return-address stack.
- Contains a direct-mapped BTB, a 2-bit saturating counter per entry, and a circular RAS.
- Lookup has one-cycle registered latency, aligned with the IF→ID pipeline register.

---
 rtl/branch_predict_unit.sv | 107 ++++++++++
 tb/tb_branch_predict_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: IF-stage predictor with a direct-mapped BTB, 2-bit counters and a circular RAS.
module branch_predict_unit #(
  parameter int BTB_IDX_W = 8,
  parameter int TAG_W = 10,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  input  logic        IF_LookupEn,
  input  logic        IF_Stall,
  input  logic        IF_Flush,
  output logic        IF_PResult_Valid,
  output logic [2:0]  IF_PResult_Type,
  output logic        IF_PResult_Taken,
  output logic [31:0] IF_PResult_Target,
  output logic [1:0]  IF_PResult_Count,
  output logic        IF_PResult_Hit,
  input  logic        EXE_BResult_Valid,
  input  logic [2:0]  EXE_BResult_Type,
  input  logic        EXE_BResult_IsTaken,
  input  logic [31:0] EXE_BResult_Target,
  input  logic [31:0] EXE_BResult_PC,
  input  logic [1:0]  EXE_BResult_Count,
  input  logic        EXE_BResult_Hit
);
  localparam int N = 1 << BTB_IDX_W;
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [2:0] B_NONE = 3'd0, B_BRAN = 3'd1, B_JUMP = 3'd2, B_CALL = 3'd3, B_RETN = 3'd4;
  logic [N-1:0] btb_vld;
  logic [TAG_W-1:0] btb_tag [N];
  logic [2:0] btb_type [N];
  logic [31:0] btb_tgt [N];
  logic [1:0] btb_cnt [N];
  logic [31:0] ras [RAS_DEPTH];
  logic [RW-1:0] ras_ptr;
  logic [RW:0] ras_occ;
  logic [BTB_IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic l_hit, l_taken;
  logic [2:0] l_type;
  logic [1:0] l_cnt, u_cnt;
  logic [31:0] l_tgt, ras_top;
  assign l_idx = IF_PC[BTB_IDX_W+1:2];
  assign l_tag = IF_PC[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  assign u_idx = EXE_BResult_PC[BTB_IDX_W+1:2];
  assign u_tag = EXE_BResult_PC[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
  // ras_ptr names the next free slot, so the top sits one below it
  assign ras_top = ras[ras_ptr - RW'(1)];
  always_comb begin
    l_hit = btb_vld[l_idx] && (btb_tag[l_idx] == l_tag);
    l_type = l_hit ? btb_type[l_idx] : B_NONE;
    l_cnt = l_hit ? btb_cnt[l_idx] : 2'b01;
    l_taken = l_hit && ((l_type == B_BRAN) ? btb_cnt[l_idx][1] : (l_type inside {B_JUMP, B_CALL, B_RETN}));
    l_tgt = !l_taken ? IF_PC + 32'd8 :
            (l_type == B_RETN && ras_occ != '0) ? ras_top : btb_tgt[l_idx];
    u_cnt = (EXE_BResult_Type != B_BRAN) ? 2'b11 :
            !EXE_BResult_Hit ? (EXE_BResult_IsTaken ? 2'b10 : 2'b01) :
            EXE_BResult_IsTaken ? ((EXE_BResult_Count == 2'b11) ? 2'b11 : EXE_BResult_Count + 2'd1) :
            ((EXE_BResult_Count == 2'b00) ? 2'b00 : EXE_BResult_Count - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld <= '0;
      ras_ptr <= '0;
      ras_occ <= '0;
      IF_PResult_Valid <= 1'b0;
      IF_PResult_Type <= '0;
      IF_PResult_Taken <= 1'b0;
      IF_PResult_Target <= '0;
      IF_PResult_Count <= '0;
      IF_PResult_Hit <= 1'b0;
    end else begin
      if (!IF_Stall) begin
        IF_PResult_Valid <= IF_LookupEn && !IF_Flush;
        if (IF_LookupEn && !IF_Flush) begin
          IF_PResult_Type <= l_type;
          IF_PResult_Taken <= l_taken;
          IF_PResult_Target <= l_tgt;
          IF_PResult_Count <= l_cnt;
          IF_PResult_Hit <= l_hit;
        end
      end
      if (EXE_BResult_Valid) begin
        if (EXE_BResult_Type != B_NONE) btb_vld[u_idx] <= 1'b1;
        else if (btb_tag[u_idx] == u_tag) btb_vld[u_idx] <= 1'b0;
        if (EXE_BResult_Type == B_CALL) begin
          ras_ptr <= ras_ptr + RW'(1);
          ras_occ <= (ras_occ == (RW+1)'(RAS_DEPTH)) ? ras_occ : ras_occ + (RW+1)'(1);
        end else if (EXE_BResult_Type == B_RETN && ras_occ != '0) begin
          ras_ptr <= ras_ptr - RW'(1);
          ras_occ <= ras_occ - (RW+1)'(1);
        end
      end
    end
  end
  // Payload storage is never reset; only the valid bits and RAS bookkeeping are
  always_ff @(posedge clk) begin
    if (!rst && EXE_BResult_Valid && EXE_BResult_Type != B_NONE) begin
      btb_tag[u_idx] <= u_tag;
      btb_type[u_idx] <= EXE_BResult_Type;
      btb_tgt[u_idx] <= EXE_BResult_Target;
      btb_cnt[u_idx] <= u_cnt;
    end
    if (!rst && EXE_BResult_Valid && EXE_BResult_Type == B_CALL) ras[ras_ptr] <= EXE_BResult_PC + 32'd8;
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard bench comparing the predictor against a queue/array reference model.
module tb_branch_predict_unit;
  logic clk = 0, rst = 1;
  logic [31:0] if_pc = 0;
  logic if_lookup_en = 0, if_stall = 0, if_flush = 0;
  logic p_valid, p_taken, p_hit;
  logic [2:0] p_type;
  logic [31:0] p_target;
  logic [1:0] p_count;
  logic b_valid = 0, b_taken = 0, b_hit = 0;
  logic [2:0] b_type = 0;
  logic [31:0] b_target = 0, b_pc = 0;
  logic [1:0] b_count = 0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  branch_predict_unit dut (
    .clk(clk), .rst(rst), .IF_PC(if_pc), .IF_LookupEn(if_lookup_en), .IF_Stall(if_stall),
    .IF_Flush(if_flush), .IF_PResult_Valid(p_valid), .IF_PResult_Type(p_type),
    .IF_PResult_Taken(p_taken), .IF_PResult_Target(p_target), .IF_PResult_Count(p_count),
    .IF_PResult_Hit(p_hit), .EXE_BResult_Valid(b_valid), .EXE_BResult_Type(b_type),
    .EXE_BResult_IsTaken(b_taken), .EXE_BResult_Target(b_target), .EXE_BResult_PC(b_pc),
    .EXE_BResult_Count(b_count), .EXE_BResult_Hit(b_hit)
  );
  typedef struct {
    logic v;
    logic [9:0] tag;
    logic [2:0] ty;
    logic [31:0] tgt;
    int cnt;
  } ent_t;
  typedef struct {
    logic v;
    logic known;
    logic [2:0] ty;
    logic tk;
    logic [31:0] tgt;
    logic [1:0] cnt;
    logic hit;
  } out_t;
  ent_t btb [256];
  logic [31:0] ras_q [$];
  out_t m_out;
  out_t sb [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // One clock of stimulus: drive, predict the registered response, then apply the training update
  task automatic cyc(input logic r, input logic [31:0] pc, input logic le, input logic st, input logic fl,
                     input logic uv, input logic [2:0] ut, input logic tk, input logic [31:0] utgt,
                     input logic [31:0] upc, input logic [1:0] uc, input logic uh);
    int li, ui, c;
    @(negedge clk);
    rst = r; if_pc = pc; if_lookup_en = le; if_stall = st; if_flush = fl;
    b_valid = uv; b_type = ut; b_taken = tk; b_target = utgt; b_pc = upc; b_count = uc; b_hit = uh;
    if (r) begin
      foreach (btb[i]) btb[i].v = 0;
      ras_q.delete();
      m_out = '{v: 0, known: 1, ty: 0, tk: 0, tgt: 0, cnt: 0, hit: 0};
    end else begin
      if (!st) begin
        if (le && !fl) begin
          li = int'(pc[9:2]);
          m_out.v = 1; m_out.known = 1;
          m_out.hit = btb[li].v && btb[li].tag == pc[19:10];
          m_out.ty = m_out.hit ? btb[li].ty : 3'd0;
          m_out.cnt = m_out.hit ? 2'(btb[li].cnt) : 2'b01;
          m_out.tk = !m_out.hit ? 1'b0 : (m_out.ty == 1) ? m_out.cnt[1] : (m_out.ty >= 2 && m_out.ty <= 4);
          if (!m_out.tk) m_out.tgt = pc + 8;
          else if (m_out.ty == 4 && ras_q.size() > 0) m_out.tgt = ras_q[$];
          else m_out.tgt = btb[li].tgt;
        end else begin
          m_out.v = 0; m_out.known = 0;
        end
      end
      if (uv) begin
        ui = int'(upc[9:2]);
        if (ut == 0) begin
          if (btb[ui].tag == upc[19:10]) btb[ui].v = 0;
        end else begin
          if (ut != 1) c = 3;
          else if (!uh) c = tk ? 2 : 1;
          else c = tk ? ((int'(uc) + 1 > 3) ? 3 : int'(uc) + 1) : ((int'(uc) - 1 < 0) ? 0 : int'(uc) - 1);
          btb[ui] = '{v: 1, tag: upc[19:10], ty: ut, tgt: utgt, cnt: c};
        end
        if (ut == 3) begin
          if (ras_q.size() == 8) void'(ras_q.pop_front());
          ras_q.push_back(upc + 8);
        end else if (ut == 4 && ras_q.size() > 0) void'(ras_q.pop_back());
      end
    end
    sb.push_back(m_out);
  endtask
  task automatic lk(input logic [31:0] pc);
    cyc(0, pc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic up(input logic [2:0] ut, input logic tk, input logic [31:0] upc, input logic [31:0] utgt,
                    input logic [1:0] uc, input logic uh);
    cyc(0, 0, 0, 0, 0, 1, ut, tk, utgt, upc, uc, uh);
  endtask
  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("valid", 32'(p_valid), 32'(e.v));
        if (e.known) begin
          check("type", 32'(p_type), 32'(e.ty));
          check("taken", 32'(p_taken), 32'(e.tk));
          check("target", p_target, e.tgt);
          check("count", 32'(p_count), 32'(e.cnt));
          check("hit", 32'(p_hit), 32'(e.hit));
        end
      end
    end
  end
  initial begin : driver
    logic [31:0] pc;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lk(32'hBFC0_0000);
    up(1, 1, 32'h8000_1000, 32'h8000_2000, 2'b00, 0);
    lk(32'h8000_1000);
    up(1, 1, 32'h8000_1000, 32'h8000_2000, 2'b10, 1);
    lk(32'h8000_1000);
    up(1, 1, 32'h8000_1000, 32'h8000_2000, 2'b11, 1);
    lk(32'h8000_1000);
    up(1, 0, 32'h8000_1000, 32'h8000_2000, 2'b01, 1);
    lk(32'h8000_1000);
    up(1, 0, 32'h8000_1000, 32'h8000_2000, 2'b00, 1);
    lk(32'h8000_1000);
    up(4, 1, 32'h8000_4010, 32'h8000_7770, 2'b11, 0);
    up(3, 1, 32'h8000_3000, 32'h8000_4000, 2'b11, 0);
    lk(32'h8000_4010);
    for (int i = 0; i < 9; i++) up(3, 1, 32'h8000_5000 + 32'(i) * 16, 32'h8000_4000, 2'b11, 1);
    lk(32'h8000_4010);
    for (int i = 0; i < 8; i++) up(4, 1, 32'h8000_4010, 32'h8000_7770, 2'b11, 1);
    lk(32'h8000_4010);
    up(4, 1, 32'h8000_4010, 32'h8000_7770, 2'b11, 1);
    lk(32'h8000_4010);
    cyc(0, 32'h8000_1000, 1, 0, 0, 1, 2, 1, 32'h8000_9000, 32'h8000_1000, 2'b00, 1);
    lk(32'h8000_1000);
    for (int i = 0; i < 3; i++) cyc(0, 32'hBFC0_0000, 1, 1, i == 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h8000_1000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    lk(32'h8010_1000);
    up(0, 0, 32'h8000_1000, 0, 2'b00, 1);
    lk(32'h8000_1000);
    cyc(1, 32'h8000_1000, 1, 0, 0, 1, 3, 1, 32'h1234, 32'h8000_1000, 2'b11, 1);
    lk(32'h8000_1000);
    for (int i = 0; i < 3000; i++) begin
      pc = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 2);
      cyc($urandom_range(0, 299) == 0, pc, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 4)),
          1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
          32'h8000_0000 | (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 2),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
